// File: rtl/status_flags.sv
// 6502 processor status register: captures ALU flags and other flag sources,
// evaluates branch conditions, and owns NMI edge detection and IRQ masking.
module status_flags #(
  parameter logic [7:0] P_RESET = 8'h34
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RDY,
  input  logic [3:0] flag_op,
  input  logic       CO,
  input  logic       V,
  input  logic       Z,
  input  logic       N,
  input  logic [7:0] DB,
  input  logic       brk_push,
  input  logic [2:0] cond,
  input  logic       sync,
  input  logic       NMI,
  input  logic       IRQ,
  input  logic       int_ack,
  output logic [7:0] P,
  output logic [7:0] P_push,
  output logic       cond_true,
  output logic       take_int,
  output logic       int_nmi
);

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic i_mask_q, i_mask_d;
  logic nmi_prev_q, nmi_prev_d;
  logic nmi_pend_q, nmi_pend_d;
  logic flag_sel;
  logic unused_db;

  // Bits 5:4 of a pulled status byte have no storage behind them.
  assign unused_db = ^DB[5:4];

  always_comb begin
    n_d        = n_q;
    v_d        = v_q;
    d_d        = d_q;
    i_d        = i_q;
    z_d        = z_q;
    c_d        = c_q;
    i_mask_d   = i_mask_q;
    nmi_pend_d = nmi_pend_q;
    nmi_prev_d = NMI;

    if (RDY) begin
      case (flag_op)
        4'b0001: begin n_d = N; z_d = Z; end
        4'b0010: begin n_d = N; z_d = Z; c_d = CO; end
        4'b0011: begin n_d = N; z_d = Z; c_d = CO; v_d = V; end
        4'b0100: begin n_d = DB[7]; v_d = DB[6]; z_d = Z; end
        4'b0101: begin
          n_d = DB[7]; v_d = DB[6]; d_d = DB[3];
          i_d = DB[2]; z_d = DB[1]; c_d = DB[0];
        end
        4'b0110: c_d = 1'b0;
        4'b0111: c_d = 1'b1;
        4'b1000: i_d = 1'b0;
        4'b1001: i_d = 1'b1;
        4'b1010: d_d = 1'b0;
        4'b1011: d_d = 1'b1;
        4'b1100: v_d = 1'b0;
        4'b1101: i_d = 1'b1;
        default: ;
      endcase
      // The mask lags I by one instruction so CLI/SEI/PLP act one boundary late.
      if (sync)    i_mask_d   = i_q;
      if (int_ack) nmi_pend_d = 1'b0;
    end

    // A fresh edge wins over a simultaneous acknowledge.
    if (NMI && !nmi_prev_q) nmi_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q        <= P_RESET[7];
      v_q        <= P_RESET[6];
      d_q        <= P_RESET[3];
      i_q        <= P_RESET[2];
      z_q        <= P_RESET[1];
      c_q        <= P_RESET[0];
      i_mask_q   <= 1'b1;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      n_q        <= n_d;
      v_q        <= v_d;
      d_q        <= d_d;
      i_q        <= i_d;
      z_q        <= z_d;
      c_q        <= c_d;
      i_mask_q   <= i_mask_d;
      nmi_prev_q <= nmi_prev_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  always_comb begin
    case (cond[2:1])
      2'b00:   flag_sel = n_q;
      2'b01:   flag_sel = v_q;
      2'b10:   flag_sel = c_q;
      default: flag_sel = z_q;
    endcase
  end

  assign cond_true = (flag_sel == cond[0]);
  assign P         = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
  assign P_push    = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
  assign take_int  = sync & (nmi_pend_q | (IRQ & ~i_mask_q));
  assign int_nmi   = nmi_pend_q;

endmodule

// File: tb/tb_status_flags.sv
// Scoreboard bench for status_flags: expectations are queued as stimulus is
// driven and drained against the DUT outputs after each step.
module tb_status_flags;

  logic       clk = 1'b0;
  logic       reset, RDY, CO, V, Z, N, brk_push, sync, NMI, IRQ, int_ack;
  logic [3:0] flag_op;
  logic [7:0] DB;
  logic [2:0] cond;
  logic [7:0] P, P_push;
  logic       cond_true, take_int, int_nmi;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  localparam int S_P = 0, S_PUSH = 1, S_COND = 2, S_TAKE = 3, S_NMI = 4;

  status_flags #(.P_RESET(8'h34)) dut (
    .clk(clk), .reset(reset), .RDY(RDY), .flag_op(flag_op),
    .CO(CO), .V(V), .Z(Z), .N(N), .DB(DB), .brk_push(brk_push),
    .cond(cond), .sync(sync), .NMI(NMI), .IRQ(IRQ), .int_ack(int_ack),
    .P(P), .P_push(P_push), .cond_true(cond_true),
    .take_int(take_int), .int_nmi(int_nmi)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_obs(input int sel);
    case (sel)
      S_P:     return P;
      S_PUSH:  return P_push;
      S_COND:  return {7'd0, cond_true};
      S_TAKE:  return {7'd0, take_int};
      default: return {7'd0, int_nmi};
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [7:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, get_obs(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] op;
    logic       n, z, co, v;
    logic [7:0] db;
    logic [7:0] exp_p;
  } op_vec_t;

  op_vec_t ops[$] = '{
    '{4'hB, 0, 0, 0, 0, 8'h00, 8'h3C},
    '{4'h8, 0, 0, 0, 0, 8'h00, 8'h38},
    '{4'hD, 0, 0, 0, 0, 8'h00, 8'h3C},
    '{4'h3, 0, 1, 0, 1, 8'h00, 8'h7E},
    '{4'hC, 0, 0, 0, 0, 8'h00, 8'h3E},
    '{4'h1, 1, 0, 1, 1, 8'h00, 8'hBC},
    '{4'hE, 0, 1, 0, 0, 8'hFF, 8'hBC},
    '{4'h2, 0, 0, 1, 1, 8'h00, 8'h3D},
    '{4'hA, 0, 0, 0, 0, 8'h00, 8'h35},
    '{4'h5, 0, 0, 0, 0, 8'hFF, 8'hFF},
    '{4'h5, 1, 1, 1, 1, 8'h30, 8'h30}
  };

  initial begin
    reset = 1; RDY = 1; flag_op = 0; CO = 0; V = 0; Z = 0; N = 0; DB = 0;
    brk_push = 0; cond = 0; sync = 0; NMI = 0; IRQ = 0; int_ack = 0;
    tick(); tick();
    reset = 0;
    push_exp("rst_p", S_P, 8'h34);
    push_exp("rst_push", S_PUSH, 8'h24);
    push_exp("rst_take", S_TAKE, 8'h00);
    push_exp("rst_nmi", S_NMI, 8'h00);
    tick(); drain();

    // ALU capture
    flag_op = 4'b0011; CO = 1; V = 1; Z = 0; N = 1;
    push_exp("alu_p", S_P, 8'hF5);
    push_exp("alu_push0", S_PUSH, 8'hE5);
    tick(); flag_op = 0; drain();
    brk_push = 1; push_exp("alu_push1", S_PUSH, 8'hF5);
    #1; drain(); brk_push = 0;

    // PLP then BIT
    flag_op = 4'b0101; DB = 8'h00;
    push_exp("plp_p", S_P, 8'h30);
    tick(); drain();
    flag_op = 4'b0100; DB = 8'hC0; Z = 1;
    push_exp("bit_p", S_P, 8'hF2);
    tick(); drain();

    // Branch conditions with C=1, Z=0, N=0, V=0
    flag_op = 4'b0101; DB = 8'h01;
    push_exp("c1_p", S_P, 8'h31);
    tick(); flag_op = 0; drain();
    for (int i = 0; i < 8; i++) begin
      logic [3:0] fl;
      fl = {1'b0, 1'b0, 1'b1, 1'b0};  // {N,V,C,Z}
      cond = 3'(i);
      push_exp($sformatf("cond%0d", i), S_COND, {7'd0, fl[3 - (i >> 1)] == cond[0]});
      #1; drain();
    end

    // IRQ mask latency after CLI
    flag_op = 4'b1001; tick();
    IRQ = 1; flag_op = 4'b1000; tick(); flag_op = 0;
    sync = 1;
    push_exp("irq_sync1", S_TAKE, 8'h00);
    #1; drain(); tick();
    sync = 0; tick(); tick();
    sync = 1;
    push_exp("irq_sync2", S_TAKE, 8'h01);
    push_exp("irq_isnmi", S_NMI, 8'h00);
    #1; drain();
    IRQ = 0;
    push_exp("irq_drop", S_TAKE, 8'h00);
    #1; drain();
    sync = 0;

    // NMI edge captured while stalled, ack gated by RDY
    RDY = 0; NMI = 1;
    push_exp("nmi_stall", S_NMI, 8'h01);
    tick(); drain();
    sync = 1; push_exp("nmi_take", S_TAKE, 8'h01); #1; drain(); sync = 0;
    int_ack = 1;
    push_exp("ack_stall", S_NMI, 8'h01);
    tick(); drain();
    RDY = 1;
    push_exp("ack_clr", S_NMI, 8'h00);
    tick(); drain();
    int_ack = 0; NMI = 0; tick();
    NMI = 1; tick(); NMI = 0; tick();
    NMI = 1; int_ack = 1;
    push_exp("edge_ack", S_NMI, 8'h01);
    tick(); drain();
    push_exp("ack_level", S_NMI, 8'h00);
    tick(); drain();
    int_ack = 0;

    // Frozen flag update, then reset over pending NMI
    flag_op = 4'b0110; push_exp("clc", S_P, 8'h30); tick(); drain();
    flag_op = 4'b0111; RDY = 0; push_exp("sec_stall", S_P, 8'h30); tick(); drain();
    RDY = 1; push_exp("sec_go", S_P, 8'h31); tick(); drain();
    flag_op = 0; NMI = 0; tick();
    NMI = 1; push_exp("pend_pre", S_NMI, 8'h01); tick(); drain();
    NMI = 0; tick(); NMI = 1; reset = 1;
    push_exp("rst2_p", S_P, 8'h34);
    push_exp("rst2_nmi", S_NMI, 8'h00);
    tick(); drain();
    NMI = 0; tick(); reset = 0; tick();

    // Remaining flag ops from reset state
    foreach (ops[k]) begin
      flag_op = ops[k].op; N = ops[k].n; Z = ops[k].z;
      CO = ops[k].co; V = ops[k].v; DB = ops[k].db;
      push_exp($sformatf("op%0d_%h", k, ops[k].op), S_P, ops[k].exp_p);
      tick(); drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
